// File: rtl/mux_display_scan.sv
// Four-digit multiplexed hex display scanner with frame-synchronous, tear-free value updates.
// Optional leading-zero blanking is compiled in by defining MUX_DISPLAY_LEADING_ZERO_BLANK_EN.
module mux_display_scan #(
  parameter int CLK_DIV = 50000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [15:0] i_Dato,
  input  logic        i_Cargar,
  output logic [3:0]  o_Bits,
  output logic [3:0]  o_Anodos,
  output logic        o_Frame
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  typedef enum logic {
    PH_DEAD,
    PH_LIT
  } phase_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pending_q, pending_d;
  logic          pend_flag_q, pend_flag_d;
  logic [3:0]    bits_q, bits_d;
  logic [3:0]    anodos_q, anodos_d;
  logic          frame_q, frame_d;
  phase_t        phase_q, phase_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    next_nibble;

`ifdef MUX_DISPLAY_LEADING_ZERO_BLANK_EN
  // A digit is dark when it and every digit to its left is zero; digit 0 never blanks.
  logic blank;

  always_comb begin
    case (idx_q)
      2'd1:    blank = (active_q[15:4] == 12'h000);
      2'd2:    blank = (active_q[15:8] == 8'h00);
      2'd3:    blank = (active_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`endif

  assign tick = (presc_q == PRE_MAX);
  assign wrap = tick && (idx_q == 2'd3);

  always_comb begin
    case (idx_d)
      2'd0:    next_nibble = active_d[3:0];
      2'd1:    next_nibble = active_d[7:4];
      2'd2:    next_nibble = active_d[11:8];
      default: next_nibble = active_d[15:12];
    endcase
  end

  always_comb begin
    presc_d     = tick ? '0 : presc_q + PW'(1);
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    frame_d     = wrap;
    bits_d      = bits_q;
    anodos_d    = anodos_q;
    phase_d     = phase_q;

    // Active only changes at the frame boundary, so a frame never mixes two values.
    if (wrap) begin
      if (i_Cargar) begin
        active_d = i_Dato;
      end else if (pend_flag_q) begin
        active_d = pending_q;
      end
      pend_flag_d = 1'b0;
    end else if (i_Cargar) begin
      pending_d   = i_Dato;
      pend_flag_d = 1'b1;
    end

    if (tick) begin
      bits_d   = next_nibble;
      anodos_d = 4'b1111;
      phase_d  = PH_DEAD;
    end else if (phase_q == PH_DEAD) begin
`ifdef MUX_DISPLAY_LEADING_ZERO_BLANK_EN
      anodos_d = blank ? 4'b1111 : ~(4'b0001 << idx_q);
`else
      anodos_d = ~(4'b0001 << idx_q);
`endif
      phase_d  = PH_LIT;
    end
  end

  // Reset parks the scan on digit 3 in the lit phase so the first tick is a frame wrap.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      presc_q     <= '0;
      idx_q       <= 2'd3;
      active_q    <= 16'h0000;
      pending_q   <= 16'h0000;
      pend_flag_q <= 1'b0;
      bits_q      <= 4'h0;
      anodos_q    <= 4'b1111;
      frame_q     <= 1'b0;
      phase_q     <= PH_LIT;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      bits_q      <= bits_d;
      anodos_q    <= anodos_d;
      frame_q     <= frame_d;
      phase_q     <= phase_d;
    end
  end

  assign o_Bits   = bits_q;
  assign o_Anodos = anodos_q;
  assign o_Frame  = frame_q;

endmodule

// File: doc/mux_display_scan.md
MUX_DISPLAY_SCAN -- requirements
Module: mux_display_scan

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL provide port i_Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port i_Dato  input  16  four hex digits; [3:0] = digit 0 (rightmost).
REQ-005 SHALL provide port i_Cargar  input  1  load strobe; i_Dato sampled on any edge with i_Cargar=1.
REQ-006 SHALL provide port o_Bits  output  4  nibble of the selected digit, feeds the binary-to-7-segment decoder.
REQ-007 SHALL provide port o_Anodos  output  4  digit enables, active-low, one-hot-low or all-high; bit n = digit n.
REQ-008 SHALL provide port o_Frame  output  1  one-cycle pulse at each frame wrap.

Function
REQ-009 SHALL run prescaler 0..CLK_DIV-1, wrapping to 0; tick = prescaler at CLK_DIV-1.
REQ-010 SHALL hold 2-bit digit index; each tick advances it 0->1->2->3->0.
REQ-011 SHALL hold active register (displayed value) and pending register plus pending flag.
REQ-012 SHALL, on i_Cargar=1 with no wrap tick, write i_Dato to pending and set pending flag; repeated loads overwrite pending, last wins.
REQ-013 SHALL, on wrap tick (index 3->0) with pending flag set, copy pending to active and clear the flag; no tearing within a frame.
REQ-014 SHALL, on i_Cargar=1 coinciding with wrap tick, load i_Dato directly into active and clear the pending flag.
REQ-015 SHALL pulse o_Frame for exactly the cycle after every wrap tick, whether or not active changed.
REQ-016 SHALL, on the edge ending a tick cycle, drive o_Bits with the new digit's nibble of the (updated) active register and force o_Anodos to 4'b1111 (one dead cycle).
REQ-017 SHALL, on the following edge, drive the new digit's anode low; it and o_Bits remain stable until the next tick.
REQ-018 SHALL keep o_Bits, o_Anodos and o_Frame fully registered; no combinational path from inputs to outputs.
REQ-019 SHALL never assert more than one anode low in any cycle.

Reset
REQ-020 SHALL, while i_Rst_n=0, immediately and without a clock force prescaler=0, digit index=3, active=16'h0000, pending=16'h0000, pending flag=0, o_Bits=4'h0, o_Anodos=4'b1111, o_Frame=0.
REQ-021 SHALL, after release, produce the first tick after CLK_DIV edges; it is a wrap tick (3->0).
REQ-022 SHALL, on reset asserted mid-scan, discard the pending load; no partial update survives.

Configuration
REQ-023 SHALL compile leading-zero blanking only when macro MUX_DISPLAY_LEADING_ZERO_BLANK_EN is defined.
REQ-024 SHALL, with the macro defined, hold o_Anodos=4'b1111 for the whole slot of digit n (n=1..3) when active[15:4n] is all zero; digit 0 always lit; o_Bits and slot timing unchanged.
REQ-025 SHALL, with the macro undefined, light all four digits including leading zeros; no blanking logic present.

Verification (CLK_DIV=4)
REQ-026 SHALL cover reset: hold i_Rst_n=0 -> o_Anodos=4'b1111, o_Bits=0, o_Frame=0; after release, unchanged for 4 edges.
REQ-027 SHALL cover first load: i_Cargar=1, i_Dato=16'h1234 in the first cycle after release -> at first tick o_Frame=1, o_Bits=4; next cycle o_Anodos=4'b1110; then per slot 3/1101, 2/1011, 1/0111, each preceded by one 1111 cycle.
REQ-028 SHALL cover mid-frame load: during digit-1 slot of 16'h1234 load 16'hABCD -> digits 2,3 still show 2,1; next frame shows D,C,B,A.
REQ-029 SHALL cover coincident load: i_Cargar=1, i_Dato=16'h00F0 exactly on a wrap-tick cycle with different pending value -> digit 0 shows 0 from 16'h00F0, pending flag cleared, next frame unchanged.
REQ-030 SHALL cover blanking: active=16'h0005 -> macro defined: only 4'b1110 ever asserted, o_Bits=5; macro undefined: 1110/1101/1011/0111 with o_Bits 5,0,0,0.
REQ-031 SHALL cover asynchronous reset mid-scan: drop i_Rst_n between edges while o_Anodos=4'b1101 -> o_Anodos=4'b1111 before the next edge; pending load lost.
